// File: rtl/msk_sbox_layer_seq.sv
// msk_sbox_layer_seq: initiator/sequencer for the masked Ascon substitution layer.
// Captures a d-share masked 320-bit state (64 columns x 5 rows), streams column
// groups through NLANES masked 5-bit S-boxes (HPC2 ANDs, latency 2) while
// consuming one fresh randomness word per issue, and writes results back in place.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a layer (sampled only in IDLE)
//   state_in/out       masked state, row r col c shares at [((r*64)+c)*d +: d]
//   busy, done         busy in RUN/DRAIN; done pulses in first IDLE cycle
//   rnd_in/valid/ready randomness handshake; lane l uses [l*5*NRND +: 5*NRND]

// msk_sbox5: masked Ascon 5-bit S-box, two register stages.
// Ports: clk; x/y rows r at [r*D +: D]; rnd holds 5 AND slices of NRND bits.
module msk_sbox5 #(
   parameter int D = 2
) (
   input  logic                         clk,
   input  logic [5*D-1:0]               x,
   input  logic [5*((D*(D-1))/2)-1:0]   rnd,
   output logic [5*D-1:0]               y
);
   localparam int NRND = (D*(D-1))/2;

   function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
      int unsigned lo, hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo*D - (lo*(lo+1))/2 + (hi-lo-1);
   endfunction

   logic [D-1:0]          a    [5];
   logic [D-1:0]          a_s1 [5];
   logic [NRND-1:0]       rr_s1[5];
   logic [D-1:0][D-1:0]   qr_s1[5];
   logic [D-1:0]          a_s2 [5];
   logic [D-1:0]          ab_s2[5];
   logic [D-1:0][D-1:0]   u_s2 [5];
   logic [D-1:0][D-1:0]   w_s2 [5];
   logic [D-1:0]          t    [5];
   logic [D-1:0]          b    [5];

   // share-wise linear input layer
   always_comb begin
      a[0] = x[0*D +: D] ^ x[4*D +: D];
      a[1] = x[1*D +: D];
      a[2] = x[2*D +: D] ^ x[1*D +: D];
      a[3] = x[3*D +: D];
      a[4] = x[4*D +: D] ^ x[3*D +: D];
   end

   // HPC2 AND k computes (~a[k]) & a[k+1]; the NOT is folded into share 0 of
   // the first operand. Stage 1 blinds the cross-share operand with r_ij.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < 5; k++) begin
         a_s1[k]  <= a[k];
         rr_s1[k] <= rnd[k*NRND +: NRND];
         for (int unsigned i = 0; i < D; i++)
            for (int unsigned j = 0; j < D; j++)
               qr_s1[k][i][j] <= (i == j) ? 1'b0 :
                                 a[(k+1)%5][j] ^ rnd[k*NRND + pidx(i, j)];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < 5; k++) begin
         a_s2[k] <= a_s1[k];
         for (int unsigned i = 0; i < D; i++) begin
            ab_s2[k][i] <= (a_s1[k][i] ^ (i == 0)) & a_s1[(k+1)%5][i];
            for (int unsigned j = 0; j < D; j++) begin
               u_s2[k][i][j] <= (i == j) ? 1'b0 :
                                ~(a_s1[k][i] ^ (i == 0)) & rr_s1[k][pidx(i, j)];
               w_s2[k][i][j] <= (a_s1[k][i] ^ (i == 0)) & qr_s1[k][i][j];
            end
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < 5; k++)
         for (int unsigned i = 0; i < D; i++)
            t[k][i] = ab_s2[k][i] ^ (^u_s2[k][i]) ^ (^w_s2[k][i]);
      for (int unsigned k = 0; k < 5; k++)
         b[k] = a_s2[k] ^ t[(k+1)%5];
      y[0*D +: D] = b[0] ^ b[4];
      y[1*D +: D] = b[1] ^ b[0];
      y[2*D +: D] = b[2] ^ D'(1);
      y[3*D +: D] = b[3] ^ b[2];
      y[4*D +: D] = b[4];
   end
endmodule

module msk_sbox_layer_seq #(
   parameter int d      = 2,
   parameter int NLANES = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [320*d-1:0]                    state_in,
   output logic                                busy,
   output logic                                done,
   output logic [320*d-1:0]                    state_out,
   input  logic [NLANES*5*((d*(d-1))/2)-1:0]   rnd_in,
   input  logic                                rnd_valid,
   output logic                                rnd_ready
);
   localparam int NRND = (d*(d-1))/2;
   localparam int NG   = 64/NLANES;
   localparam int GW   = $clog2(NG+1);
   localparam int IW   = $clog2(320*d);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      g_q, wb_q;
   logic [1:0]         v_q;
   logic [GW-1:0]      gidx_q [2];
   logic               done_q;
   logic [320*d-1:0]   st_q;
   logic               issue, last_wb;
   logic [5*d-1:0]     lane_x [NLANES];
   logic [5*d-1:0]     lane_y [NLANES];

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign state_out = st_q;

   always_comb begin
      state_d   = state_q;
      rnd_ready = 1'b0;
      issue     = 1'b0;
      last_wb   = v_q[1] && (wb_q == GW'(NG-1));
      case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN: begin
            rnd_ready = (g_q < GW'(NG));
            issue     = rnd_ready && rnd_valid;
            if (issue && (g_q == GW'(NG-1))) state_d = DRAIN;
         end
         DRAIN: if (last_wb) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // column gather for group g_q
   always_comb begin
      for (int unsigned l = 0; l < NLANES; l++) begin
         lane_x[l] = '0;
         for (int unsigned r = 0; r < 5; r++)
            lane_x[l][r*d +: d] = st_q[IW'((r*64 + g_q*NLANES + l)*d) +: d];
      end
   end

   for (genvar l = 0; l < NLANES; l++) begin : g_lane
      msk_sbox5 #(.D(d)) u_sbox (
         .clk (clk),
         .x   (lane_x[l]),
         .rnd (rnd_in[l*5*NRND +: 5*NRND]),
         .y   (lane_y[l])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         g_q       <= '0;
         wb_q      <= '0;
         v_q       <= '0;
         gidx_q[0] <= '0;
         gidx_q[1] <= '0;
         done_q    <= 1'b0;
         st_q      <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= (state_q == DRAIN) && last_wb;
         v_q       <= {v_q[0], issue};
         gidx_q[0] <= g_q;
         gidx_q[1] <= gidx_q[0];
         if ((state_q == IDLE) && start) begin
            st_q <= state_in;
            g_q  <= '0;
            wb_q <= '0;
         end else begin
            if (issue) g_q <= g_q + GW'(1);
            // writeback targets group g-2 or older, never the group being read
            if (v_q[1]) begin
               wb_q <= wb_q + GW'(1);
               for (int unsigned l = 0; l < NLANES; l++)
                  for (int unsigned r = 0; r < 5; r++)
                     st_q[IW'((r*64 + gidx_q[1]*NLANES + l)*d) +: d] <= lane_y[l][r*d +: d];
            end
         end
      end
   end
endmodule

// File: tb/tb_msk_sbox_layer_seq.sv
// Self-checking bench for msk_sbox_layer_seq: randomized masks, randomness and
// rnd_valid patterns, checked against an Ascon S-box table model on the
// recombined state, plus cycle-accurate handshake/latency expectations.
module tb_msk_sbox_layer_seq;
   localparam int D      = 2;
   localparam int NLANES = 4;
   localparam int NG     = 64/NLANES;
   localparam int NRND   = (D*(D-1))/2;
   localparam int RW     = NLANES*5*NRND;

   logic               clk = 1'b0;
   logic               rst, start, rnd_valid;
   logic               busy, done, rnd_ready;
   logic [320*D-1:0]   state_in, state_out;
   logic [RW-1:0]      rnd_in;

   int total = 0;
   int bad   = 0;

   logic [4:0] col_val  [64];
   logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                  5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                  5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                  5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   always #5 clk = ~clk;

   msk_sbox_layer_seq #(.d(D), .NLANES(NLANES)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .state_in  (state_in),
      .busy      (busy),
      .done      (done),
      .state_out (state_out),
      .rnd_in    (rnd_in),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] row_of(input int r);
      logic [63:0] v;
      for (int c = 0; c < 64; c++) v[c] = ^state_out[((r*64)+c)*D +: D];
      return v;
   endfunction

   function automatic logic [63:0] exp_row(input int r);
      logic [63:0] v;
      logic [4:0]  s;
      for (int c = 0; c < 64; c++) begin
         s    = sbox_tab[col_val[c]];
         v[c] = s[4-r];
      end
      return v;
   endfunction

   task automatic load_state(input bit zero);
      logic [D-1:0] sh;
      logic [4:0]   cv;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 64; c++) begin
            cv = col_val[c];
            sh = zero ? '0 : D'($urandom);
            sh[D-1] = cv[4-r] ^ (^sh[D-2:0]);
            state_in[((r*64)+c)*D +: D] = sh;
         end
   endtask

   // mode 0: rnd_valid always 1; 1: toggling 1,0,...; 2: random
   task automatic run_layer(input string name, input int mode, input int restart_at,
                            input bit zero, output int dcyc);
      int issued, last_iss;
      bit vld;
      load_state(zero);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      issued   = 0;
      last_iss = 0;
      dcyc     = 0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (done) begin
            dcyc = cyc;
            break;
         end
         check({name, " ready"}, 64'(rnd_ready), 64'(issued < NG));
         check({name, " busy"}, 64'(busy), 64'd1);
         case (mode)
            0:       vld = 1'b1;
            1:       vld = (cyc % 2) == 1;
            default: vld = $urandom_range(0, 3) != 0;
         endcase
         rnd_valid = vld;
         rnd_in    = zero ? '0 : RW'({$urandom(), $urandom()});
         start     = (cyc == restart_at);
         if (vld && issued < NG) begin
            issued++;
            last_iss = cyc;
         end
         @(posedge clk); #1;
      end
      rnd_valid = 1'b0;
      start     = 1'b0;
      if (dcyc == 0) begin
         check({name, " timeout"}, 64'd0, 64'd1);
      end else begin
         check({name, " done_cycle"}, 64'(dcyc), 64'(last_iss + 3));
         check({name, " busy_at_done"}, 64'(busy), 64'd0);
         check({name, " ready_at_done"}, 64'(rnd_ready), 64'd0);
         for (int r = 0; r < 5; r++)
            check($sformatf("%s row%0d", name, r), row_of(r), exp_row(r));
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check({name, " done_pulse"}, 64'(done), 64'd0);
         check({name, " idle"}, 64'(busy), 64'd0);
      end
      for (int r = 0; r < 5; r++)
         check($sformatf("%s hold row%0d", name, r), row_of(r), exp_row(r));
   endtask

   initial begin
      int dc;
      rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_in = '0; state_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst ready", 64'(rnd_ready), 64'd0);
      check("rst state", 64'(|state_out), 64'd0);

      for (int c = 0; c < 64; c++) col_val[c] = 5'd0;
      run_layer("zero", 0, 0, 1'b1, dc);
      check("zero latency", 64'(dc), 64'd19);

      for (int c = 0; c < 64; c++) col_val[c] = 5'h1f;
      run_layer("ones_a", 0, 0, 1'b0, dc);
      run_layer("ones_b", 0, 0, 1'b0, dc);

      for (int c = 0; c < 64; c++) col_val[c] = 5'(c % 32);
      run_layer("ramp_toggle", 1, 0, 1'b0, dc);
      check("toggle latency", 64'(dc), 64'(2*NG + 2));

      for (int n = 0; n < 3; n++) begin
         for (int c = 0; c < 64; c++) col_val[c] = 5'($urandom);
         run_layer($sformatf("rand%0d", n), 2, 0, 1'b0, dc);
      end

      for (int c = 0; c < 64; c++) col_val[c] = 5'($urandom);
      run_layer("restart", 0, 5, 1'b0, dc);
      check("restart latency", 64'(dc), 64'd19);

      // reset in cycle 8 of a run
      for (int c = 0; c < 64; c++) col_val[c] = 5'($urandom);
      load_state(1'b0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc < 8; cyc++) begin
         rnd_valid = 1'b1;
         rnd_in    = RW'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      check("midrst ready", 64'(rnd_ready), 64'd0);
      check("midrst state", 64'(|state_out), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check("midrst no_stale", 64'(|state_out), 64'd0);
         check("midrst no_done", 64'(done), 64'd0);
      end
      rnd_valid = 1'b0;
      for (int c = 0; c < 64; c++) col_val[c] = 5'($urandom);
      run_layer("post_rst", 0, 0, 1'b0, dc);
      check("post_rst latency", 64'(dc), 64'd19);

      // start in the same cycle as rst is ignored
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check("rst_start busy", 64'(busy), 64'd0);
      check("rst_start ready", 64'(rnd_ready), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
